// File: rtl/evdev_pkg.sv
// Shared evdev definitions: event word layout, event types and codes.
// No logic; constants and one helper only.
// Imported by the event scheduler and by every evdev producer.
package evdev_pkg;

  localparam logic [15:0] EV_SYN         = 16'h0000;
  localparam logic [15:0] EV_KEY         = 16'h0001;
  localparam logic [7:0]  SYN_REPORT     = 8'h00;
  localparam logic [7:0]  KEY_EVENT_UP   = 8'h00;
  localparam logic [7:0]  KEY_EVENT_DOWN = 8'h01;

  // One evdev event as carried on every 32-bit event bus.
  typedef struct packed {
    logic [15:0] ev_type;
    logic [7:0]  code;
    logic [7:0]  value;
  } evdev_event_t;

  // EV_SYN / SYN_REPORT / 0, closing a key report.
  localparam evdev_event_t EVDEV_SYN_WORD = '{ev_type: EV_SYN, code: SYN_REPORT, value: 8'h00};

  function automatic logic is_key_event(input evdev_event_t ev);
    return ev.ev_type == EV_KEY;
  endfunction

endpackage

// File: rtl/evdev_fifo.sv
// First-word-fall-through FIFO, DEPTH entries (power of two), occupancy output.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full is ignored (callers gate on level); pop while empty is ignored.
module evdev_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_100mhz,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit, so full is exactly level[AW].
  assign level      = wr_ptr - rd_ptr;
  assign head_valid = (wr_ptr != rd_ptr);
  assign head_data  = mem[rd_ptr[AW-1:0]];
  assign do_push    = push && !level[AW];
  assign do_pop     = pop && head_valid;

  // Storage and pointer update; memory is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/evdev_event_sched.sv
// Merges NSRC evdev producers round-robin into one FWFT event FIFO; EVDEV_SCHED_SYN_EN appends SYN_REPORT after EV_KEY.
// Latency: done pulse to ev_valid is 2 cycles on an empty, uncontended FIFO.
// Backpressure: full FIFO parks events in per-source slots; a new pulse on a parked source is dropped and counted.
module evdev_event_sched
  import evdev_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     clk_100mhz,
  input  logic                     rst,
  input  logic [NSRC*32-1:0]       src_data,
  input  logic [NSRC-1:0]          src_done,
  output logic [31:0]              ev_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int RR_W  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CNT_W = 4;
  localparam int SW    = DROP_W + CNT_W;

  logic [NSRC-1:0] pending;
  logic [31:0]     slot [NSRC];
  logic [RR_W-1:0] rr;
  logic            arb_en;
  logic            gnt_vld;
  logic [RR_W-1:0] gnt_idx;
  logic [NSRC-1:0] gnt_oh;
  logic [NSRC-1:0] drop_vec;
  logic [CNT_W-1:0] n_drop;
  logic [SW-1:0]   drop_sum;
  logic [DROP_W-1:0] drop_nxt;
  logic            push;
  logic [31:0]     push_data;

`ifdef EVDEV_SCHED_SYN_EN
  logic         syn_pend;
  evdev_event_t gnt_ev;

  // A key event and its SYN are written back to back, so both slots must be free up front.
  assign gnt_ev    = slot[gnt_idx];
  assign arb_en    = !syn_pend && (level < LW'(DEPTH - 1));
  assign push      = gnt_vld || syn_pend;
  assign push_data = syn_pend ? EVDEV_SYN_WORD : slot[gnt_idx];

  // Schedule the SYN write for the cycle after a granted EV_KEY.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) syn_pend <= 1'b0;
    else     syn_pend <= gnt_vld && is_key_event(gnt_ev);
  end
`else
  assign arb_en    = !level[AW];
  assign push      = gnt_vld;
  assign push_data = slot[gnt_idx];
`endif

  // Round-robin search from rr; scanning backwards leaves the first hit after rr.
  always_comb begin
    logic [RR_W-1:0] cand;
    int              idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    idx     = 0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      cand = RR_W'(idx);
      if (arb_en && pending[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot grant plus the set of sources whose new pulse finds a parked, ungranted slot.
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NSRC; i++) gnt_oh[i] = gnt_vld && (gnt_idx == RR_W'(i));
    drop_vec = src_done & pending & ~gnt_oh;
  end

  // Saturating drop counter next-value, adding every drop of this cycle at once.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NSRC; i++) n_drop = n_drop + CNT_W'(drop_vec[i]);
    drop_sum = SW'(drop_cnt) + SW'(n_drop);
    if (drop_sum[SW-1:DROP_W] != '0) drop_nxt = {DROP_W{1'b1}};
    else                             drop_nxt = drop_sum[DROP_W-1:0];
  end

  // Capture stage: a granted slot may be refilled in the same cycle it drains.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NSRC; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (src_done[i] && (!pending[i] || gnt_oh[i])) begin
          slot[i]    <= src_data[32*i +: 32];
          pending[i] <= 1'b1;
        end else if (gnt_oh[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances past the winner; holds when nothing is granted.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      rr <= '0;
    end else if (gnt_vld) begin
      rr <= (gnt_idx == RR_W'(NSRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= drop_nxt;
  end

  evdev_fifo #(
    .DW    (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (ev_ready),
    .head_data  (ev_data),
    .head_valid (ev_valid),
    .level      (level)
  );

endmodule

// File: tb/tb_evdev_event_sched.sv
// Self-checking bench for evdev_event_sched (NSRC=2, DEPTH=8, DROP_W=8).
// Expected event words are queued when stimulus is driven and compared on each popped beat.
// Honours EVDEV_SCHED_SYN_EN for the SYN word and the reduced fill level.
module tb_evdev_event_sched;

  localparam int NSRC  = 2;
  localparam int DEPTH = 8;
`ifdef EVDEV_SCHED_SYN_EN
  localparam int FULL_LVL = DEPTH - 1;
`else
  localparam int FULL_LVL = DEPTH;
`endif

  logic              clk_100mhz = 1'b0;
  logic              rst        = 1'b1;
  logic [NSRC*32-1:0] src_data  = '0;
  logic [NSRC-1:0]   src_done   = '0;
  logic [31:0]       ev_data;
  logic              ev_valid;
  logic              ev_ready   = 1'b0;
  logic [3:0]        level;
  logic [7:0]        drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] sb_q [$];

  evdev_event_sched #(.NSRC(NSRC), .DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .src_data   (src_data),
    .src_done   (src_done),
    .ev_data    (ev_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] w);
    sb_q.push_back(w);
`ifdef EVDEV_SCHED_SYN_EN
    if (w[31:16] == 16'h0001) sb_q.push_back(32'h0000_0000);
`endif
  endtask

  // Drive one done pulse (called #1 after an edge), return #1 after the sampling edge.
  task automatic pulse(input logic [NSRC-1:0] m, input logic [31:0] d0, input logic [31:0] d1);
    src_data = {d1, d0};
    src_done = m;
    @(posedge clk_100mhz); #1;
    src_done = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'b0, ev_valid}, 32'd0);
    chk("rst_level", {28'b0, level}, 32'd0);
    chk("rst_drop",  {24'b0, drop_cnt}, 32'd0);
    sb_q.delete();
    idle(2);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    ev_ready = 1'b1;
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk_100mhz);
    #1;
    chk("drain_left", sb_q.size(), 32'd0);
    idle(2);
    chk("drain_level", {28'b0, level}, 32'd0);
  endtask

  // Scoreboard: every accepted beat must match the oldest expected word.
  always @(negedge clk_100mhz) begin
    if (!rst && ev_valid && ev_ready) begin
      if (sb_q.size() == 0) chk("spurious_beat", {31'b0, ev_valid}, 32'd0);
      else                  chk("beat", ev_data, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    chk("rst_data", ev_data, 32'd0);
    do_reset();
    idle(1);

    // Single event, latency 2.
    ev_ready = 1'b1;
    exp_push(32'h0001_1E01);
    pulse(2'b01, 32'h0001_1E01, 32'h0);
    chk("lat_cycle1", {31'b0, ev_valid}, 32'd0);
    idle(1);
    chk("lat_cycle2", {31'b0, ev_valid}, 32'd1);
    chk("lat_data", ev_data, 32'h0001_1E01);
    drain(20);
    chk("single_drop", {24'b0, drop_cnt}, 32'd0);

    // Contention with rr = 0: A then B.
    do_reset();
    idle(1);
    ev_ready = 1'b1;
    exp_push(32'h0002_00A0);
    exp_push(32'h0002_00B0);
    pulse(2'b11, 32'h0002_00A0, 32'h0002_00B0);
    drain(20);
    // Move rr to 1, then contention yields source 1 first.
    exp_push(32'h0002_0011);
    pulse(2'b01, 32'h0002_0011, 32'h0);
    drain(20);
    exp_push(32'h0002_00D1);
    exp_push(32'h0002_00C0);
    pulse(2'b11, 32'h0002_00C0, 32'h0002_00D1);
    drain(20);

    // Same-cycle grant and capture on one source.
    exp_push(32'h0002_0101);
    exp_push(32'h0002_0102);
    pulse(2'b01, 32'h0002_0101, 32'h0);
    pulse(2'b01, 32'h0002_0102, 32'h0);
    drain(20);
    chk("samecyc_drop", {24'b0, drop_cnt}, 32'd0);

    // Back-pressure: fill, park one per source, drop the next.
    do_reset();
    idle(1);
    ev_ready = 1'b0;
    for (int k = 0; k < FULL_LVL + 3; k++) begin
      w = 32'h0002_0000 | k;
      if (k < FULL_LVL + 2) exp_push(w);
      if (k % 2 == 0) pulse(2'b01, w, 32'h0);
      else            pulse(2'b10, 32'h0, w);
      idle(1);
    end
    idle(2);
    chk("bp_level", {28'b0, level}, FULL_LVL);
    chk("bp_drop1", {24'b0, drop_cnt}, 32'd1);
    chk("bp_head", ev_data, 32'h0002_0000);
    pulse(2'b11, 32'h0002_0EE0, 32'h0002_0EE1);
    chk("bp_drop_pair", {24'b0, drop_cnt}, 32'd3);
    src_done = 2'b11;
    idle(130);
    src_done = 2'b00;
    chk("bp_drop_sat", {24'b0, drop_cnt}, 32'd255);
    drain(200);

    // Reset in the middle of a stream.
    do_reset();
    idle(1);
    ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse(2'b01, 32'h0002_0200 | k, 32'h0);
      idle(1);
    end
    idle(1);
    chk("mid_level5", {28'b0, level}, 32'd5);
    pulse(2'b10, 32'h0, 32'h0002_02FF);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, ev_valid}, 32'd0);
    chk("mid_rst_level", {28'b0, level}, 32'd0);
    chk("mid_rst_drop",  {24'b0, drop_cnt}, 32'd0);
    sb_q.delete();
    idle(2);
    rst = 1'b0;
    ev_ready = 1'b1;
    idle(4);
    chk("mid_no_stale", {31'b0, ev_valid}, 32'd0);
    exp_push(32'h0001_1C01);
    pulse(2'b10, 32'h0, 32'h0001_1C01);
    drain(20);

`ifdef EVDEV_SCHED_SYN_EN
    // A key event waits at DEPTH-1 until a pop frees the second slot.
    ev_ready = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      exp_push(32'h0002_0300 | k);
      pulse(2'b01, 32'h0002_0300 | k, 32'h0);
      idle(1);
    end
    exp_push(32'h0001_1E00);
    pulse(2'b10, 32'h0, 32'h0001_1E00);
    idle(3);
    chk("syn_wait_level", {28'b0, level}, DEPTH - 1);
    drain(100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
